// File: rtl/debug_session_ctrl.sv
// debug_session_ctrl: command sequencer for the MIPS debug unit.
// Decodes UART command bytes, gates the CPU pipeline enable for continuous
// run or single step, and requests a state-dump frame after every stop.
//
// Optional feature macro: DBG_BREAKPOINT_EN (adds pc port, 'b' command and
// breakpoint register; without it 'b' is an unknown byte).
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   rx_done/rx_data one-cycle byte strobe and byte from the UART receiver
//   cpu_halted      CPU has retired its halt instruction (level)
//   send_done       transmitter status: 1 idle/finished, 0 frame in progress
//   pc              current CPU PC (DBG_BREAKPOINT_EN only)
//   cpu_en          CPU pipeline enable (combinational in RUN/STEP)
//   send_req        one-cycle frame send request (state == REPORT)
//   cycle_count     number of cycles with cpu_en = 1, wraps, reset-only clear
//   cmd_err         one-cycle error strobe, the cycle after the cause
//   ctrl_state      current state code
module debug_session_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    input  logic        cpu_halted,
    input  logic        send_done,
`ifdef DBG_BREAKPOINT_EN
    input  logic [31:0] pc,
`endif
    output logic        cpu_en,
    output logic        send_req,
    output logic [31:0] cycle_count,
    output logic        cmd_err,
    output logic [2:0]  ctrl_state
);

    localparam logic [7:0] CMD_CONT = 8'h63;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_DUMP = 8'h64;
`ifdef DBG_BREAKPOINT_EN
    localparam logic [7:0] CMD_BP   = 8'h62;
`endif
    localparam int unsigned ACK_TIMEOUT = 16;
    localparam int unsigned ACK_W       = $clog2(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        STEP      = 3'd2,
        REPORT    = 3'd3,
        WAIT_ACK  = 3'd4,
        WAIT_DONE = 3'd5,
        LOAD_BP   = 3'd6
    } state_t;

    state_t             state, state_nxt;
    logic [ACK_W-1:0]   ack_cnt, ack_cnt_nxt;
    logic               cmd_err_nxt;
    logic               bp_hit;

`ifdef DBG_BREAKPOINT_EN
    logic [31:0] bp_addr;
    logic        bp_valid;
    logic [1:0]  bp_cnt;
    logic        first_run;
`endif

    // State register and registered datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ack_cnt     <= '0;
            cmd_err     <= 1'b0;
            cycle_count <= '0;
        end else begin
            state   <= state_nxt;
            ack_cnt <= ack_cnt_nxt;
            cmd_err <= cmd_err_nxt;
            if (cpu_en) begin
                cycle_count <= cycle_count + 32'd1;
            end
        end
    end

`ifdef DBG_BREAKPOINT_EN
    // Breakpoint register: 4 bytes shifted in MSB first while in LOAD_BP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bp_addr   <= '0;
            bp_valid  <= 1'b0;
            bp_cnt    <= '0;
            first_run <= 1'b0;
        end else begin
            first_run <= (state != RUN) && (state_nxt == RUN);
            if (state == IDLE && rx_done && rx_data == CMD_BP) begin
                bp_cnt <= '0;
            end else if (state == LOAD_BP && rx_done) begin
                bp_addr <= {bp_addr[23:0], rx_data};
                bp_cnt  <= bp_cnt + 2'd1;
                if (bp_cnt == 2'd3) begin
                    bp_valid <= 1'b1;
                end
            end
        end
    end

    // Masked on the first RUN cycle so 'c' can resume from the breakpoint PC
    assign bp_hit = (state == RUN) && bp_valid && (pc == bp_addr) && !first_run;
`else
    assign bp_hit = 1'b0;
`endif

    // Next-state and output decode
    always_comb begin
        state_nxt   = state;
        ack_cnt_nxt = ack_cnt;
        cmd_err_nxt = 1'b0;
        cpu_en      = 1'b0;
        send_req    = 1'b0;

        // Bytes are only consumed in IDLE and LOAD_BP
        if (rx_done && state != IDLE && state != LOAD_BP) begin
            cmd_err_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (rx_done) begin
                    case (rx_data)
                        CMD_CONT: state_nxt = RUN;
                        CMD_STEP: state_nxt = STEP;
                        CMD_DUMP: state_nxt = REPORT;
`ifdef DBG_BREAKPOINT_EN
                        CMD_BP:   state_nxt = LOAD_BP;
`endif
                        default:  cmd_err_nxt = 1'b1;
                    endcase
                end
            end
            RUN: begin
                cpu_en = !cpu_halted && !bp_hit;
                if (cpu_halted || bp_hit) begin
                    state_nxt = REPORT;
                end
            end
            STEP: begin
                cpu_en    = !cpu_halted;
                state_nxt = REPORT;
            end
            REPORT: begin
                send_req    = 1'b1;
                ack_cnt_nxt = '0;
                state_nxt   = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!send_done) begin
                    state_nxt = WAIT_DONE;
                end else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
                    cmd_err_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    ack_cnt_nxt = ack_cnt + ACK_W'(1);
                end
            end
            WAIT_DONE: begin
                if (send_done) begin
                    state_nxt = IDLE;
                end
            end
            LOAD_BP: begin
`ifdef DBG_BREAKPOINT_EN
                if (rx_done && bp_cnt == 2'd3) begin
                    state_nxt = IDLE;
                end
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ctrl_state = state;

endmodule

// File: tb/tb_debug_session_ctrl.sv
// Self-checking bench for debug_session_ctrl: directed scenarios followed by
// randomized command traffic, all checked every cycle against a reference
// model expressed in spec terms (state codes, deadline cycles, counters).
`timescale 1ns/1ps
module tb_debug_session_ctrl;

    localparam logic [7:0] C_CONT = 8'h63;
    localparam logic [7:0] C_STEP = 8'h73;
    localparam logic [7:0] C_DUMP = 8'h64;
    localparam logic [7:0] C_BP   = 8'h62;
    localparam int ACK_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        cpu_halted = 1'b0;
    logic        send_done = 1'b1;
    logic [31:0] pc = 32'h0040_0000;
    logic        cpu_en, send_req, cmd_err;
    logic [31:0] cycle_count;
    logic [2:0]  ctrl_state;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    debug_session_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .cpu_halted (cpu_halted),
        .send_done  (send_done),
`ifdef DBG_BREAKPOINT_EN
        .pc         (pc),
`endif
        .cpu_en     (cpu_en),
        .send_req   (send_req),
        .cycle_count(cycle_count),
        .cmd_err    (cmd_err),
        .ctrl_state (ctrl_state)
    );

    // Reference model state (spec state codes)
    int          m_st;
    logic [31:0] m_cnt;
    bit          m_err;
    int          m_deadline;
    bit          m_bpv;
    logic [31:0] m_bp;
    int          m_bpn;
    bit          m_fresh;
    int          cyc = 0;

    // Transmitter behaviour: absolute cycles where send_done is low
    int drop_at = -1;
    int rise_at = -1;
    bit tx_rand = 0;
    bit tx_never = 0;
    int tx_d1 = 2;
    int tx_d2 = 20;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    task automatic m_reset();
        m_st = 0; m_cnt = 0; m_err = 0; m_deadline = 0;
        m_bpv = 0; m_bp = 0; m_bpn = 0; m_fresh = 0;
        drop_at = -1; rise_at = -1; send_done = 1'b1;
    endtask

    function automatic bit m_hit();
`ifdef DBG_BREAKPOINT_EN
        return m_st == 1 && m_bpv && pc == m_bp && !m_fresh;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_en();
        return (m_st == 1 && !cpu_halted && !m_hit()) || (m_st == 2 && !cpu_halted);
    endfunction

    // Apply one clock edge to the model using this cycle's inputs
    task automatic advance(input bit en);
        int nx;
        bit err;
        nx  = m_st;
        err = 0;
        if (en) m_cnt = m_cnt + 32'd1;
        case (m_st)
            0: if (rx_done) begin
                   if (rx_data == C_CONT) nx = 1;
                   else if (rx_data == C_STEP) nx = 2;
                   else if (rx_data == C_DUMP) nx = 3;
`ifdef DBG_BREAKPOINT_EN
                   else if (rx_data == C_BP) begin nx = 6; m_bpn = 0; end
`endif
                   else err = 1;
               end
            1: if (cpu_halted || m_hit()) nx = 3;
            2: nx = 3;
            3: begin nx = 4; m_deadline = cyc + ACK_TIMEOUT; end
            4: if (!send_done) nx = 5;
               else if (cyc == m_deadline) begin err = 1; nx = 0; end
            5: if (send_done) nx = 0;
            6: if (rx_done) begin
                   m_bp = {m_bp[23:0], rx_data};
                   m_bpn++;
                   if (m_bpn == 4) begin m_bpv = 1; nx = 0; end
               end
            default: nx = 0;
        endcase
        if (rx_done && m_st != 0 && m_st != 6) err = 1;
        if (nx == 3) begin
            if (tx_rand) begin
                tx_never = ($urandom_range(0, 4) == 0);
                tx_d1 = $urandom_range(1, 5);
                tx_d2 = $urandom_range(1, 12);
            end
            if (tx_never) begin drop_at = -1; rise_at = -1; end
            else begin drop_at = cyc + 1 + tx_d1; rise_at = drop_at + tx_d2; end
        end
        m_fresh = (nx == 1 && m_st != 1);
        m_err = err;
        m_st = nx;
    endtask

    // One clock cycle: compare, clock, update model, drive next-cycle inputs
    task automatic tick();
        bit en;
        #1;
        en = exp_en();
        chk("cpu_en",      32'(cpu_en),     32'(en));
        chk("send_req",    32'(send_req),   32'(m_st == 3));
        chk("cmd_err",     32'(cmd_err),    32'(m_err));
        chk("ctrl_state",  32'(ctrl_state), 32'(m_st));
        chk("cycle_count", cycle_count,     m_cnt);
        @(posedge clk);
        advance(en);
        cyc++;
        @(negedge clk);
        if (en) pc = pc + 32'd4;
        send_done = !(cyc >= drop_at && cyc < rise_at);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_done = 1'b1;
        rx_data = b;
        tick();
        rx_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        @(negedge clk);
        #1;
        chk("reset_cpu_en",   32'(cpu_en),     32'd0);
        chk("reset_send_req", 32'(send_req),   32'd0);
        chk("reset_cmd_err",  32'(cmd_err),    32'd0);
        chk("reset_count",    cycle_count,     32'd0);
        chk("reset_state",    32'(ctrl_state), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) tick();

        // Single step
        send_byte(C_STEP);
        #1;
        chk("step_en",    32'(cpu_en),     32'd1);
        chk("step_state", 32'(ctrl_state), 32'd2);
        tick();
        #1;
        chk("step_req",    32'(send_req), 32'd1);
        chk("step_en_off", 32'(cpu_en),   32'd0);
        tick();
        #1;
        chk("step_wait_ack", 32'(ctrl_state), 32'd4);
        repeat (25) tick();
        #1;
        chk("step_count", cycle_count,     32'd1);
        chk("step_idle",  32'(ctrl_state), 32'd0);

        // Continuous run, halt after 100 enabled cycles
        send_byte(C_CONT);
        repeat (100) tick();
        cpu_halted = 1'b1;
        #1;
        chk("halt_en",    32'(cpu_en),     32'd0);
        chk("halt_state", 32'(ctrl_state), 32'd1);
        chk("halt_count", cycle_count,     32'd101);
        tick();
        #1;
        chk("halt_req", 32'(send_req), 32'd1);
        repeat (30) tick();

        // Run while already halted: zero enabled cycles
        send_byte(C_CONT);
        #1;
        chk("rehalt_en", 32'(cpu_en), 32'd0);
        tick();
        #1;
        chk("rehalt_req",   32'(send_req), 32'd1);
        chk("rehalt_count", cycle_count,   32'd101);
        repeat (30) tick();

        // Dump with transmitter never responding: ack timeout
        tx_never = 1;
        send_byte(C_DUMP);
        #1;
        chk("dump_req", 32'(send_req), 32'd1);
        chk("dump_en",  32'(cpu_en),   32'd0);
        repeat (16) tick();
        #1;
        chk("dump_wait_last", 32'(ctrl_state), 32'd4);
        chk("dump_err_early", 32'(cmd_err),    32'd0);
        tick();
        #1;
        chk("dump_timeout_err", 32'(cmd_err),    32'd1);
        chk("dump_timeout_st",  32'(ctrl_state), 32'd0);
        tick();
        tx_never = 0;

        // Unknown byte in IDLE
        send_byte(8'h41);
        #1;
        chk("unk_err",   32'(cmd_err),    32'd1);
        chk("unk_state", 32'(ctrl_state), 32'd0);
        tick();
        #1;
        chk("unk_err_pulse", 32'(cmd_err), 32'd0);

        // Step command while the frame is in flight is rejected
        send_byte(C_DUMP);
        repeat (3) tick();
        #1;
        chk("wd_state", 32'(ctrl_state), 32'd5);
        send_byte(C_STEP);
        #1;
        chk("wd_err",   32'(cmd_err),    32'd1);
        chk("wd_stay",  32'(ctrl_state), 32'd5);
        chk("wd_no_en", 32'(cpu_en),     32'd0);
        repeat (25) tick();
        #1;
        chk("wd_count", cycle_count,     32'd101);
        chk("wd_idle",  32'(ctrl_state), 32'd0);

`ifdef DBG_BREAKPOINT_EN
        // Breakpoint at 0x00400020, PC ramps from 0x00400000
        send_byte(C_BP);
        #1;
        chk("bp_load_state", 32'(ctrl_state), 32'd6);
        send_byte(8'h00);
        send_byte(8'h40);
        send_byte(8'h00);
        send_byte(8'h20);
        #1;
        chk("bp_loaded_idle", 32'(ctrl_state), 32'd0);
        cpu_halted = 1'b0;
        pc = 32'h0040_0000;
        send_byte(C_CONT);
        repeat (8) tick();
        #1;
        chk("bp_pc",    pc,              32'h0040_0020);
        chk("bp_en",    32'(cpu_en),     32'd0);
        chk("bp_count", cycle_count,     32'd109);
        tick();
        #1;
        chk("bp_req", 32'(send_req), 32'd1);
        repeat (30) tick();
        send_byte(C_CONT);
        #1;
        chk("bp_resume_en", 32'(cpu_en), 32'd1);
        repeat (5) tick();
        cpu_halted = 1'b1;
        #1;
        chk("bp_resume_count", cycle_count, 32'd114);
        repeat (30) tick();
`else
        send_byte(C_BP);
        #1;
        chk("bp_unknown_err", 32'(cmd_err),    32'd1);
        chk("bp_unknown_st",  32'(ctrl_state), 32'd0);
        tick();
`endif

        // Randomized traffic
        tx_rand = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) cpu_halted = ~cpu_halted;
            rx_done = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 7))
                0: rx_data = C_CONT;
                1: rx_data = C_STEP;
                2: rx_data = C_DUMP;
                3: rx_data = C_BP;
                4: rx_data = 8'h41;
                default: rx_data = 8'($urandom);
            endcase
            tick();
        end
        rx_done = 1'b0;
        tx_rand = 0;
        tx_never = 0;
        tx_d1 = 2;
        tx_d2 = 20;
        begin
            int n;
            n = 0;
            while (m_st != 0 && n < 100) begin
                tick();
                n++;
            end
        end
        #1;
        chk("rand_drain_idle", 32'(ctrl_state), 32'd0);

        // Asynchronous reset in the middle of RUN
        cpu_halted = 1'b0;
        send_byte(C_CONT);
        repeat (3) tick();
        #1;
        chk("pre_reset_en", 32'(cpu_en), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_en",    32'(cpu_en),     32'd0);
        chk("async_rst_req",   32'(send_req),   32'd0);
        chk("async_rst_state", 32'(ctrl_state), 32'd0);
        chk("async_rst_count", cycle_count,     32'd0);
        m_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
        send_byte(C_STEP);
        #1;
        chk("post_rst_step_en", 32'(cpu_en), 32'd1);
        repeat (30) tick();
        #1;
        chk("post_rst_count", cycle_count,     32'd1);
        chk("post_rst_idle",  32'(ctrl_state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debug_session_ctrl.md
# debug_session_ctrl

Command sequencer for the MIPS debug unit. Decodes command bytes from the UART receiver, gates the CPU clock enable for continuous run or single-step, and triggers the frame transmitter through its send/done handshake to dump processor state to the host after every stop. It sits between the UART RX interface, the CPU pipeline enable and the debug frame transmitter's `sendSignal`/`dataSent` pair.

## Interface
- `CMD_CONT`, 8'h63 ('c'): run continuously until halt or breakpoint.
- `CMD_STEP`, 8'h73 ('s'): execute exactly one CPU cycle.
- `CMD_DUMP`, 8'h64 ('d'): send a frame without executing.
- `CMD_BP`, 8'h62 ('b'): load breakpoint; used only with `DBG_BREAKPOINT_EN`.
- `ACK_TIMEOUT`, 16: cycles to wait for the transmitter to drop `send_done`.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `rx_done` in 1: one-cycle strobe; `rx_data` holds a valid byte.
- `rx_data` in 8: received command or argument byte.
- `cpu_halted` in 1: CPU has retired its halt instruction. Level signal.
- `send_done` in 1: transmitter status. 1 = idle or finished, 0 = frame in progress.
- `pc` in 32: current CPU PC. Present only with `DBG_BREAKPOINT_EN`.
- `cpu_en` out 1: CPU pipeline enable.
- `send_req` out 1: one-cycle frame send request.
- `cycle_count` out 32: number of cycles with `cpu_en`=1.
- `cmd_err` out 1: one-cycle error strobe.
- `ctrl_state` out 3: current state code, for debug visibility.

## Operation
- States and codes: IDLE=0, RUN=1, STEP=2, REPORT=3, WAIT_ACK=4, WAIT_DONE=5, LOAD_BP=6.
- **IDLE**: act on a byte when `rx_done`=1.
  - `CMD_CONT` → RUN.
  - `CMD_STEP` → STEP.
  - `CMD_DUMP` → REPORT.
  - Any other byte → `cmd_err` pulse, stay in IDLE.
- **RUN**: `cpu_en` = !`cpu_halted` && !`bp_hit` (combinational).
  - Leave to REPORT on `cpu_halted`=1 or `bp_hit`=1.
  - If `cpu_halted` is already 1 on entry: zero enabled cycles, straight to REPORT.
- **STEP**: `cpu_en` = !`cpu_halted` for exactly one cycle, then REPORT.
- **REPORT**: `send_req`=1 for one cycle, then WAIT_ACK. Clear the ack counter.
- **WAIT_ACK**:
  - `send_done`=0 → WAIT_DONE.
  - Counter reaches `ACK_TIMEOUT` with `send_done` still 1 → `cmd_err` pulse, → IDLE.
- **WAIT_DONE**: `send_done`=1 → IDLE.
- **Bytes outside IDLE/LOAD_BP**: discarded, `cmd_err` pulse, no state change. This includes a byte arriving in the same cycle RUN stops; the stop wins.
- **`cycle_count`**:
  - Increments on every cycle with `cpu_en`=1.
  - 32-bit, wraps 0xFFFFFFFF→0.
  - Never cleared except by reset.
- **`send_req`**: Moore output (state==REPORT). `cpu_en` is 0 in every state other than RUN/STEP.

## Timing
- **Reset values**: state IDLE, `cpu_en`=0, `send_req`=0, `cmd_err`=0, `cycle_count`=0, `ctrl_state`=0, `bp_valid`=0.
- **Reset mid-operation**:
  - `cpu_en` and `send_req` drop immediately (asynchronous).
  - A frame already in flight in the transmitter is not tracked.
- **Step latency** (`rx_done` for 's' at cycle N):
  - N+1: STEP, `cpu_en`=1.
  - N+2: REPORT, `send_req`=1.
  - N+3: WAIT_ACK.
- **Continuous run latency**: 'c' at N gives `cpu_en`=1 from N+1. A halt sampled at cycle M gives `cpu_en`=0 at M, REPORT at M+1.
- **Dump latency**: 'd' at N gives `send_req` at N+1.
- **`cmd_err`**: asserted the cycle after the offending `rx_done`.

## Configuration
- Macro: `DBG_BREAKPOINT_EN`.
- **Defined**:
  - The `pc` port exists.
  - `CMD_BP` in IDLE → LOAD_BP.
  - LOAD_BP shifts in 4 bytes, MSB first, one per `rx_done`, into `bp_addr`.
  - After the 4th byte: `bp_valid`=1, → IDLE.
  - `bp_hit` = `bp_valid` && `pc`==`bp_addr` && not the first RUN cycle. This lets 'c' resume from a breakpoint.
  - A new 'b' overwrites `bp_addr`.
- **Undefined**:
  - No `pc` port and no `bp_addr` register; `bp_hit` is tied to 0.
  - `CMD_BP` is an unknown byte (`cmd_err`).
  - LOAD_BP is unreachable.

## Test plan
- Reset, then 's' with `cpu_halted`=0 → `cpu_en` high exactly 1 cycle, `send_req` 1 cycle later. Transmitter model drops `send_done` 2 cycles later and raises it 20 cycles later → IDLE; `cycle_count`=1.
- 'c', raise `cpu_halted` after 100 cycles → `cycle_count`=100, `cpu_en` low the same cycle as the halt, one `send_req`. A second 'c' → `send_req` with `cycle_count` unchanged.
- 'd' → `send_req` at N+1, `cpu_en` never high. Hold `send_done`=1 → `cmd_err` after 16 cycles, state 0.
- Byte 0x41 in IDLE → `cmd_err` pulse. 's' during WAIT_DONE → `cmd_err`, no second step.
- Breakpoint build: 'b',00,40,00,20 then 'c' with `pc` ramping by 4 from 0x00400000 → stop with `pc`=0x00400020, `cycle_count`=8. A second 'c' leaves the breakpoint and runs.
- Assert `reset` while in RUN → `cpu_en`=0 and `ctrl_state`=0 without a clock edge, `cycle_count`=0.
